if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC and the IF/ID pipeline register, and drives a request/acknowledge instruction-memory port.
- Consumes `stall` from the forwarding/hazard unit and `redirect` from branch/jump resolution.
- Produces the fetched instruction that the decode stage and the hazard unit consume as `if_inst`.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word inserted for bubbles and flushes.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hold IF/ID and stop consuming fetched words (load-use hazard).
- redirect  in  1  taken branch/jump: flush and refetch from redirect_pc.
- redirect_pc  in  32  redirect target, word aligned.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ack=0.
- imem_ack  in  1  imem_data valid this cycle; completes the outstanding request.
- imem_data  in  32  fetched instruction.
- if_inst  out  32  IF/ID instruction.
- if_pc4  out  32  IF/ID fetch address + 4.
- if_valid  out  1  IF/ID holds a real instruction.
- pc  out  32  next fetch PC.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc = RESET_PC, fetch address register = RESET_PC.
  - State = FETCH, skid buffer empty.
  - if_inst = NOP_INST, if_pc4 = 0, if_valid = 0.
  - imem_req is forced to 0 while rst=0.
  - The first request is issued in the first cycle after rst deasserts.
- imem_addr comes from the fetch address register. It equals pc in FETCH and holds the abandoned address in DROP.
- Arithmetic: pc+4 and if_pc4 are 32-bit with wrap (32'hFFFF_FFFC + 4 = 0). No alignment check.
- FETCH state (imem_req=1):
  - redirect=1 has top priority:
    - pc <= redirect_pc; IF/ID <= bubble (NOP_INST, valid=0); skid cleared.
    - If imem_ack=1: data discarded, fetch address <= redirect_pc, stay in FETCH.
    - If imem_ack=0: go to DROP; the fetch address keeps the old value.
  - imem_ack=1, stall=0:
    - IF/ID <= {imem_data, imem_addr+4, valid=1}.
    - pc and fetch address <= imem_addr+4.
  - imem_ack=1, stall=1:
    - Skid <= {imem_data, imem_addr+4}; pc and fetch address advance by 4.
    - IF/ID holds; go to FULL.
  - imem_ack=0, stall=0: IF/ID <= bubble.
  - imem_ack=0, stall=1: IF/ID holds.
- FULL state (imem_req=0):
  - redirect=1: flush IF/ID and skid, pc and fetch address <= redirect_pc, go to FETCH.
  - stall=0: IF/ID <= skid (valid=1), skid empty, go to FETCH.
  - stall=1: hold everything.
- DROP state (imem_req=1, imem_addr = abandoned address):
  - Incoming data is never written to IF/ID or skid.
  - imem_ack=1: fetch address <= pc, go to FETCH.
  - redirect=1 in DROP: pc <= new redirect_pc and stay in DROP. If ack arrives in the same cycle, fetch address <= new redirect_pc.
  - IF/ID holds a bubble while stall=0.
- Simultaneous events:
  - redirect beats stall and ack in every state.
  - The flush writes the IF/ID bubble even when stall=1.
- Latency:
  - An ack in cycle N appears on if_inst after the edge ending cycle N.
  - With single-cycle ack, throughput is 1 instruction/cycle.
  - Redirect penalty is one bubble when ack is immediate.
- Reset mid-operation: any state returns immediately to the reset values above. A pending memory transaction is abandoned; the memory side must tolerate this.

Test Plan:
1. Reset and streaming:
   - Stimulus: hold rst=0 for 3 cycles, release; imem_ack=1 every cycle with data = addr.
   - Required: imem_addr = 0,4,8,...; if_inst = 0,4,8,... one cycle later; if_pc4 = 4,8,12; if_valid=1 from the second cycle after release.
2. Stall with skid:
   - Stimulus: while streaming, assert stall for 3 cycles at the ack of addr 0x10.
   - Required: imem_req=0 during cycles 2–3; if_inst holds 0x0C; after stall drops, if_inst = 0x10 then 0x14; no word lost or duplicated.
3. Redirect during pending fetch:
   - Stimulus: request at 0x20 outstanding with ack held low; redirect=1 with redirect_pc=0x100; ack 2 cycles later with data 0xDEAD.
   - Required: imem_addr stays 0x20 until that ack; 0xDEAD never reaches if_inst; next request addr = 0x100; if_valid=0 meanwhile.
4. Redirect + stall + ack same cycle in FULL:
   - Stimulus: enter FULL, then assert redirect_pc=0x200 together with stall=1.
   - Required: if_inst = NOP_INST, if_valid=0, skid discarded, next imem_addr = 0x200.
5. Wrap-around:
   - Stimulus: redirect_pc=32'hFFFF_FFFC, ack.
   - Required: if_pc4 = 0 and next imem_addr = 0.
6. Async reset mid-DROP:
   - Stimulus: pull rst low between clock edges while in DROP.
   - Required: imem_req=0, if_valid=0, pc = RESET_PC immediately, with no clock edge needed.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge port of the fetch stage.
// The fetch stage is the master (drives req/addr); memory is the slave.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, the fetch address register, a
// one-entry skid buffer and the IF/ID pipeline register. Fetches through a
// request/acknowledge memory port; honours stall and branch/jump redirect.
// States: FETCH (request outstanding), FULL (skid holds a word, no request),
// DROP (request for an abandoned address still outstanding, data discarded).
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active-low
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  if_fetch_stage_if.master imem,
  output logic [31:0]      if_inst,
  output logic [31:0]      if_pc4,
  output logic             if_valid,
  output logic [31:0]      pc
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] faddr_reg, faddr_next;
  logic [31:0] skid_inst_reg, skid_inst_next;
  logic [31:0] skid_pc4_reg, skid_pc4_next;
  logic [31:0] ifid_inst_reg, ifid_inst_next;
  logic [31:0] ifid_pc4_reg, ifid_pc4_next;
  logic        ifid_valid_reg, ifid_valid_next;
  logic [31:0] faddr_plus4;

  // Address of the word after the one currently being fetched (wraps).
  assign faddr_plus4 = faddr_reg + 32'd4;

  // Request is live in FETCH and DROP, and suppressed while reset is held.
  assign imem.imem_req  = rst && (state_reg != FULL);
  assign imem.imem_addr = faddr_reg;

  assign if_inst  = ifid_inst_reg;
  assign if_pc4   = ifid_pc4_reg;
  assign if_valid = ifid_valid_reg;
  assign pc       = pc_reg;

  // Next-state and datapath update; everything holds unless a rule fires.
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    faddr_next      = faddr_reg;
    skid_inst_next  = skid_inst_reg;
    skid_pc4_next   = skid_pc4_reg;
    ifid_inst_next  = ifid_inst_reg;
    ifid_pc4_next   = ifid_pc4_reg;
    ifid_valid_next = ifid_valid_reg;

    case (state_reg)
      FETCH: begin
        if (redirect) begin
          // Flush wins over stall; an in-flight request must be drained.
          pc_next         = redirect_pc;
          ifid_inst_next  = NOP_INST;
          ifid_valid_next = 1'b0;
          if (imem.imem_ack) begin
            faddr_next = redirect_pc;
          end else begin
            state_next = DROP;
          end
        end else if (imem.imem_ack) begin
          pc_next    = faddr_plus4;
          faddr_next = faddr_plus4;
          if (stall) begin
            // Decode cannot take it: park the word and pause fetching.
            skid_inst_next = imem.imem_data;
            skid_pc4_next  = faddr_plus4;
            state_next     = FULL;
          end else begin
            ifid_inst_next  = imem.imem_data;
            ifid_pc4_next   = faddr_plus4;
            ifid_valid_next = 1'b1;
          end
        end else if (!stall) begin
          ifid_inst_next  = NOP_INST;
          ifid_valid_next = 1'b0;
        end
      end

      FULL: begin
        if (redirect) begin
          // No request is outstanding here, so the new target is fetched next.
          pc_next         = redirect_pc;
          faddr_next      = redirect_pc;
          ifid_inst_next  = NOP_INST;
          ifid_valid_next = 1'b0;
          state_next      = FETCH;
        end else if (!stall) begin
          ifid_inst_next  = skid_inst_reg;
          ifid_pc4_next   = skid_pc4_reg;
          ifid_valid_next = 1'b1;
          state_next      = FETCH;
        end
      end

      DROP: begin
        // Returning data belongs to an abandoned address and is ignored.
        if (redirect) begin
          pc_next = redirect_pc;
        end
        if (imem.imem_ack) begin
          faddr_next = redirect ? redirect_pc : pc_reg;
          state_next = FETCH;
        end
        if (redirect || !stall) begin
          ifid_inst_next  = NOP_INST;
          ifid_valid_next = 1'b0;
        end
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // State and pipeline registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= FETCH;
      pc_reg         <= RESET_PC;
      faddr_reg      <= RESET_PC;
      skid_inst_reg  <= NOP_INST;
      skid_pc4_reg   <= 32'd0;
      ifid_inst_reg  <= NOP_INST;
      ifid_pc4_reg   <= 32'd0;
      ifid_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      faddr_reg      <= faddr_next;
      skid_inst_reg  <= skid_inst_next;
      skid_pc4_reg   <= skid_pc4_next;
      ifid_inst_reg  <= ifid_inst_next;
      ifid_pc4_reg   <= ifid_pc4_next;
      ifid_valid_reg <= ifid_valid_next;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: directed stimulus, a transaction-level model
// (held-word queue, discard flag) checked on every falling edge, plus
// hand-computed literal expectations at key points of each scenario.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ack_drv;
  logic        ovr_en;
  logic [31:0] ovr_data;
  logic [31:0] if_inst;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic [31:0] pc;

  int n_cmp  = 0;
  int n_fail = 0;

  if_fetch_stage_if im ();

  // Memory responder: returns the address as data unless overridden.
  assign im.imem_ack  = ack_drv;
  assign im.imem_data = ovr_en ? ovr_data : im.imem_addr;

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (im),
    .if_inst     (if_inst),
    .if_pc4      (if_pc4),
    .if_valid    (if_valid),
    .pc          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
  } word_t;

  word_t       held[$];      // accepted words waiting for decode (0 or 1)
  logic [31:0] m_pc, m_addr, m_inst, m_pc4;
  bit          m_valid, m_discard;

  function automatic void model_reset();
    held.delete();
    m_pc      = 32'h0;
    m_addr    = 32'h0;
    m_inst    = 32'h0;
    m_pc4     = 32'h0;
    m_valid   = 1'b0;
    m_discard = 1'b0;
  endfunction

  function automatic void bubble();
    m_inst  = 32'h0;
    m_valid = 1'b0;
  endfunction

  // Advance the model across one rising edge using the current inputs.
  function automatic void model_step();
    bit    on_bus;
    word_t w;
    on_bus = (held.size() == 0);
    if (redirect) begin
      bubble();
      held.delete();
      if (on_bus) begin
        if (ack_drv) begin
          m_addr    = redirect_pc;
          m_discard = 1'b0;
        end else begin
          m_discard = 1'b1;
        end
      end else begin
        m_addr = redirect_pc;
      end
      m_pc = redirect_pc;
    end else if (!on_bus) begin
      if (!stall) begin
        w = held.pop_front();
        m_inst  = w.inst;
        m_pc4   = w.pc4;
        m_valid = 1'b1;
      end
    end else if (m_discard) begin
      if (ack_drv) begin
        m_discard = 1'b0;
        m_addr    = m_pc;
      end
      if (!stall) bubble();
    end else begin
      if (ack_drv) begin
        w.inst = im.imem_data;
        w.pc4  = m_addr + 32'd4;
        m_addr = w.pc4;
        m_pc   = w.pc4;
        if (stall) begin
          held.push_back(w);
        end else begin
          m_inst  = w.inst;
          m_pc4   = w.pc4;
          m_valid = 1'b1;
        end
      end else if (!stall) begin
        bubble();
      end
    end
  endfunction

  // Compare every cycle away from the active edge, then step the model.
  always @(negedge clk) begin
    bit exp_req;
    if (!rst) model_reset();
    exp_req = rst && (held.size() == 0);
    chk("m_req", {31'd0, im.imem_req}, {31'd0, exp_req});
    if (exp_req) chk("m_addr", im.imem_addr, m_addr);
    chk("m_pc", pc, m_pc);
    chk("m_valid", {31'd0, if_valid}, {31'd0, m_valid});
    chk("m_inst", if_inst, m_inst);
    if (m_valid) chk("m_pc4", if_pc4, m_pc4);
    if (rst) model_step();
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic s, input logic r, input logic [31:0] rp, input logic a);
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    ack_drv     = a;
    @(posedge clk);
    #1;
    stall    = 1'b0;
    redirect = 1'b0;
    ack_drv  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    ack_drv = 1'b0; ovr_en = 1'b0; ovr_data = 32'h0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_req", {31'd0, im.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", if_pc4, 32'h0);
    rst = 1'b1;
    #1;
    chk("first_req", {31'd0, im.imem_req}, 32'd1);
    chk("first_addr", im.imem_addr, 32'h0);

    // 1. streaming
    step(0, 0, 0, 1);
    chk("s1_inst", if_inst, 32'h0); chk("s1_pc4", if_pc4, 32'h4);
    chk("s1_valid", {31'd0, if_valid}, 32'd1); chk("s1_addr", im.imem_addr, 32'h4);
    step(0, 0, 0, 1);
    chk("s2_inst", if_inst, 32'h4); chk("s2_pc4", if_pc4, 32'h8);
    step(0, 0, 0, 1);
    chk("s3_pc4", if_pc4, 32'hC);
    step(0, 0, 0, 1);
    chk("s4_inst", if_inst, 32'hC); chk("s4_addr", im.imem_addr, 32'h10);

    // 2. stall with skid at ack of 0x10
    step(1, 0, 0, 1);
    chk("k1_req", {31'd0, im.imem_req}, 32'd0); chk("k1_inst", if_inst, 32'hC);
    step(1, 0, 0, 0);
    chk("k2_req", {31'd0, im.imem_req}, 32'd0); chk("k2_inst", if_inst, 32'hC);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("k4_inst", if_inst, 32'h10); chk("k4_addr", im.imem_addr, 32'h14);
    step(0, 0, 0, 1);
    chk("k5_inst", if_inst, 32'h14);

    // 3. redirect during pending fetch at 0x20
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("d0_addr", im.imem_addr, 32'h20);
    step(0, 1, 32'h100, 0);
    chk("d1_addr", im.imem_addr, 32'h20); chk("d1_pc", pc, 32'h100);
    chk("d1_valid", {31'd0, if_valid}, 32'd0);
    step(0, 0, 0, 0);
    chk("d2_addr", im.imem_addr, 32'h20);
    ovr_en = 1'b1; ovr_data = 32'h0000_DEAD;
    step(0, 0, 0, 1);
    ovr_en = 1'b0;
    chk("d3_addr", im.imem_addr, 32'h100); chk("d3_inst", if_inst, 32'h0);
    chk("d3_valid", {31'd0, if_valid}, 32'd0);

    // 4. redirect + stall + ack in FULL
    step(0, 0, 0, 1);
    chk("f0_inst", if_inst, 32'h100);
    step(1, 0, 0, 1);
    chk("f1_req", {31'd0, im.imem_req}, 32'd0);
    step(1, 1, 32'h200, 1);
    chk("f2_inst", if_inst, 32'h0); chk("f2_valid", {31'd0, if_valid}, 32'd0);
    chk("f2_addr", im.imem_addr, 32'h200); chk("f2_req", {31'd0, im.imem_req}, 32'd1);
    step(0, 0, 0, 1);
    chk("f3_inst", if_inst, 32'h200);

    // 5. wrap-around
    step(0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 1);
    chk("w_inst", if_inst, 32'hFFFF_FFFC); chk("w_pc4", if_pc4, 32'h0);
    chk("w_addr", im.imem_addr, 32'h0);

    // redirects while draining
    step(0, 1, 32'h300, 0);
    chk("r1_addr", im.imem_addr, 32'h0); chk("r1_pc", pc, 32'h300);
    step(0, 1, 32'h400, 1);
    chk("r2_addr", im.imem_addr, 32'h400);
    step(0, 1, 32'h500, 0);
    step(1, 0, 0, 0);
    chk("r4_addr", im.imem_addr, 32'h400);

    // 6. async reset mid-DROP, between edges
    #2 rst = 1'b0;
    #1;
    chk("ar_req", {31'd0, im.imem_req}, 32'd0);
    chk("ar_valid", {31'd0, if_valid}, 32'd0);
    chk("ar_pc", pc, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // resume with mixed stalls
    step(0, 0, 0, 1);
    chk("z1_inst", if_inst, 32'h0); chk("z1_valid", {31'd0, if_valid}, 32'd1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("z3_inst", if_inst, 32'h4);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("z5_inst", if_inst, 32'h8); chk("z5_pc4", if_pc4, 32'hC);
    step(0, 0, 0, 1);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
